// File: rtl/led_frame_scheduler_pkg.sv
// Shared constants and frame-sequencer state encoding for the LED matrix display path.
// Engine and scorer import this to align with frame_done.
package led_frame_scheduler_pkg;

    localparam int          MATRIX_ROWS      = 12;
    localparam int          MATRIX_COLS      = 16;
    localparam int          PIXELS           = MATRIX_ROWS * MATRIX_COLS;
    localparam logic [23:0] GRB_GREEN        = 24'hFF0000;
    localparam logic [23:0] GRB_BLACK        = 24'h000000;
    localparam int          LATCH_GAP_CYCLES = 3000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_SEND,
        ST_DRAIN,
        ST_GAP
    } frame_state_t;

endpackage

// File: rtl/led_frame_scheduler_pixel_walker.sv
// Row/column walker in panel wiring order (optionally serpentine).
// bit_idx is the linear snapshot index of the pixel that the next advance steps to.
module pixel_walker import led_frame_scheduler_pkg::*; #(
    parameter int ROWS       = MATRIX_ROWS,
    parameter int COLS       = MATRIX_COLS,
    parameter int SERPENTINE = 1,
    localparam int IDX_W     = $clog2(ROWS * COLS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             advance,
    output logic [IDX_W-1:0] bit_idx,
    output logic             last_pixel
);

    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;

    logic [ROW_W-1:0] row, row_nx;
    logic [COL_W-1:0] col, col_nx;
    logic             rev, row_end;

    assign rev        = (SERPENTINE != 0) && row[0];
    assign row_end    = rev ? (col == '0) : (col == COL_W'(COLS - 1));
    assign last_pixel = row_end && (row == ROW_W'(ROWS - 1));

    always_comb begin
        row_nx = row;
        col_nx = rev ? col - 1'b1 : col + 1'b1;
        if (row_end) begin
            // The row after an odd row is even and vice versa.
            row_nx = row + 1'b1;
            col_nx = ((SERPENTINE != 0) && !row[0]) ? COL_W'(COLS - 1) : '0;
        end
    end

    assign bit_idx = IDX_W'(int'(row_nx) * COLS + int'(col_nx));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row <= '0;
            col <= '0;
        end else if (start) begin
            row <= '0;
            col <= '0;
        end else if (advance) begin
            row <= row_nx;
            col <= col_nx;
        end
    end

endmodule

// File: rtl/led_frame_scheduler.sv
// Per-tick frame sequencer: snapshots the tile state, streams one GRB word per pixel,
// waits for the encoder to drain, holds the latch gap and then pulses frame_done.
module led_frame_scheduler import led_frame_scheduler_pkg::*; #(
    parameter int          ROWS         = MATRIX_ROWS,
    parameter int          COLS         = MATRIX_COLS,
    parameter logic [23:0] ON_COLOR     = GRB_GREEN,
    parameter logic [23:0] OFF_COLOR    = GRB_BLACK,
    parameter int          SERPENTINE   = 1,
    parameter int          RESET_CYCLES = LATCH_GAP_CYCLES
) (
    input  logic                 CLOCK_50,
    input  logic                 reset_n,
    input  logic                 frame_tick,
    input  logic [ROWS*COLS-1:0] state_flat,
    output logic                 pix_valid,
    output logic [23:0]          pix_data,
    input  logic                 pix_ready,
    input  logic                 enc_busy,
    output logic                 frame_busy,
    output logic                 frame_done,
    output logic [7:0]           overrun_cnt
);

    localparam int PIX   = ROWS * COLS;
    localparam int IDX_W = $clog2(PIX);
    localparam int GAP_W = $clog2(RESET_CYCLES + 1);

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    frame_state_t       state, state_nx;
    logic [PIX-1:0]     snapshot;
    logic [GAP_W-1:0]   gap_cnt;
    logic [IDX_W-1:0]   next_idx;
    logic               last_pixel, xfer, walk_start, tick_drop;

    assign xfer = (state == ST_SEND) && pix_ready;

    pixel_walker #(
        .ROWS       (ROWS),
        .COLS       (COLS),
        .SERPENTINE (SERPENTINE)
    ) u_walker (
        .clk        (CLOCK_50),
        .rst_n      (reset_n),
        .start      (walk_start),
        .advance    (xfer),
        .bit_idx    (next_idx),
        .last_pixel (last_pixel)
    );

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        pix_valid  = 1'b0;
        frame_busy = 1'b1;
        frame_done = 1'b0;
        walk_start = 1'b0;
        tick_drop  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                frame_busy = 1'b0;
                if (frame_tick) state_nx = ST_LATCH;
            end
            ST_LATCH: begin
                walk_start = 1'b1;
                tick_drop  = frame_tick;
                state_nx   = ST_SEND;
            end
            ST_SEND: begin
                pix_valid = 1'b1;
                tick_drop = frame_tick;
                if (pix_ready && last_pixel) state_nx = ST_DRAIN;
            end
            ST_DRAIN: begin
                tick_drop = frame_tick;
                if (!enc_busy) state_nx = ST_GAP;
            end
            ST_GAP: begin
                // A tick landing on the last gap cycle starts the next frame back-to-back.
                if (gap_cnt == GAP_W'(RESET_CYCLES - 1)) begin
                    frame_done = 1'b1;
                    state_nx   = frame_tick ? ST_LATCH : ST_IDLE;
                end else begin
                    tick_drop = frame_tick;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            snapshot    <= '0;
            pix_data    <= '0;
            gap_cnt     <= '0;
            overrun_cnt <= '0;
        end else begin
            if (tick_drop) overrun_cnt <= sat_inc8(overrun_cnt);
            // Pixel 0 comes straight from the input since the snapshot is loading this cycle.
            if (state == ST_LATCH) begin
                snapshot <= state_flat;
                pix_data <= state_flat[0] ? ON_COLOR : OFF_COLOR;
            end else if (xfer && !last_pixel) begin
                pix_data <= snapshot[next_idx] ? ON_COLOR : OFF_COLOR;
            end
            if (state == ST_GAP) gap_cnt <= gap_cnt + 1'b1;
            else                 gap_cnt <= '0;
        end
    end

endmodule

// File: doc/led_frame_scheduler.md
Name: led_frame_scheduler

Overview:
- Sequences the WS2812 LED-matrix display path once per game tick.
- On each tick it snapshots the 12x16 tile state and streams one 24-bit GRB word per pixel, in panel wiring order, to the downstream bit encoder.
- After the last pixel it holds the line low for the WS2812 latch gap, then signals frame completion to the engine and scorer.
- Sits between the game engine (state producer) and the ws2812 bit encoder (serial datapath).

Parameters:
- ROWS, 12, matrix rows; row 0 is the top row.
- COLS, 16, matrix columns.
- ON_COLOR, 24'hFF0000, GRB word for a lit pixel (green).
- OFF_COLOR, 24'h000000, GRB word for an unlit pixel.
- SERPENTINE, 1, when 1, odd rows are sent in reverse column order.
- RESET_CYCLES, 3000, latch-gap length in CLOCK_50 cycles (60 us).

Ports:
- CLOCK_50  in  1  50 MHz system clock.
- reset_n  in  1  asynchronous active-low reset.
- frame_tick  in  1  one-cycle pulse, synchronous to CLOCK_50, derived from game_clock.
- state_flat  in  ROWS*COLS  tile state; bit r*COLS+c is row r, column c; 1 = lit.
- pix_valid  out  1  pix_data is valid.
- pix_data  out  24  GRB word for the current pixel.
- pix_ready  in  1  encoder accepts pix_data this cycle.
- enc_busy  in  1  encoder is still shifting bits.
- frame_busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse at the end of the gap.
- overrun_cnt  out  8  count of dropped ticks; saturates at 255.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state goes to IDLE.
  - pix_valid=0, pix_data=0, frame_busy=0, frame_done=0, overrun_cnt=0.
  - Row/column counters, snapshot and gap counter are cleared.
  - Reset mid-frame abandons the frame. pix_valid drops immediately, and the encoder must tolerate a truncated stream.
- FSM states: IDLE, LATCH, SEND, DRAIN, GAP.
- IDLE:
  - frame_tick=1 leads to LATCH on the next cycle.
- LATCH:
  - Captures state_flat into an internal snapshot register.
  - Sets row=0 and col=0 (or col=COLS-1 if SERPENTINE and row is odd, which is never the case for row 0).
  - Moves to SEND.
  - Changes to state_flat after LATCH do not affect the current frame.
- SEND:
  - pix_valid=1.
  - pix_data = snapshot bit at (row, col) ? ON_COLOR : OFF_COLOR. It is registered and stable while pix_valid && !pix_ready.
  - A transfer happens on pix_valid && pix_ready. The next pixel is presented in the following cycle with no bubble; pix_valid stays high.
  - Column stepping: col increments, or decrements when SERPENTINE and row is odd.
  - Row boundary: after the last column of a row, row increments and col reloads for that row's direction.
  - After the transfer of pixel ROWS*COLS-1 (192nd), pix_valid=0 and the FSM moves to DRAIN.
  - Latency: tick at cycle T, LATCH at T+1, first pix_valid at T+2.
- DRAIN:
  - Waits for enc_busy=0, then moves to GAP with the gap counter cleared.
- GAP:
  - Counts RESET_CYCLES cycles; the line idles low because the encoder is quiescent.
  - On the final count: frame_done=1 for one cycle, then IDLE.
  - If frame_tick arrives in that same final cycle, it is accepted and the next state is LATCH instead of IDLE.
- Overrun:
  - frame_tick in LATCH, SEND, DRAIN, or GAP before the final count is dropped.
  - Each dropped tick increments overrun_cnt; the counter holds at 255.
- pix_ready while pix_valid=0 is ignored.
- Total frame time with an always-ready encoder is 192 transfers plus drain plus RESET_CYCLES.

Decomposition:
- Shared package: ROWS, COLS, PIXELS=ROWS*COLS, GRB colour constants, and the FSM state encoding (also used by the engine and scorer for frame_done alignment).
- One sub-module: pixel_walker. It holds the row/column counters with serpentine direction, exposes the linear bit index and a last_pixel flag, and is advanced by an enable input.

Test Plan:
- Reset mid-SEND:
  - Stimulus: pulse reset_n low after 50 transfers.
  - Required: pix_valid=0 within the same cycle, state IDLE, overrun_cnt=0; the next tick restarts at pixel 0.
- Single frame, pix_ready tied 1, state_flat = only bit 0 and bit 16 set:
  - Transfer 0 = 24'hFF0000.
  - Transfer 31 (row 1 reversed, col 0) = 24'hFF0000.
  - All other transfers = 24'h000000.
  - Exactly 192 transfers; frame_done exactly 3000 cycles after enc_busy falls.
- Backpressure:
  - Stimulus: pix_ready toggles 1,0,0,1.
  - Required: pix_data stable during the stall, no pixel skipped or duplicated, total still 192.
- Snapshot isolation:
  - Stimulus: flip all of state_flat to 1 at transfer 10.
  - Required: remaining pixels match the value latched in LATCH.
- Overrun:
  - Stimulus: 3 ticks during SEND.
  - Required: overrun_cnt=3, a single frame sent.
  - Stimulus: 300 ticks while busy.
  - Required: overrun_cnt=255.
- Tick coincident with the final GAP cycle:
  - Required: frame_done=1 and LATCH next cycle, overrun_cnt unchanged.
